// File: rtl/asip_pkg.sv
// Shared types and constants for the 24-bit ASIP pipeline front end.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package asip_pkg;

  localparam int              IMEM_DEPTH = 256;
  localparam int              OPC_W      = 5;
  localparam logic [OPC_W-1:0] HALT_OPC  = 5'b11111;
  localparam logic [23:0]     NOP_INSTR  = 24'h0;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: captures an instruction word and its PC for decode.
// Latency: one clk edge from load/flush to outputs.
// Backpressure: holds contents when neither load nor flush is asserted; flush wins over load.
// Ports: clk/rst (async active-high), load/flush controls, d_instr/d_pc capture data,
//        ifid_instr/ifid_pc/ifid_valid registered outputs.
module ifid_reg
  import asip_pkg::*;
#(
  parameter int N = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         flush,
  input  logic [N-1:0] d_instr,
  input  logic [N-1:0] d_pc,
  output logic [N-1:0] ifid_instr,
  output logic [N-1:0] ifid_pc,
  output logic         ifid_valid
);

  logic [N-1:0] instr_q, instr_d;
  logic [N-1:0] pc_q, pc_d;
  logic         valid_q, valid_d;

  // A flushed slot becomes a NOP bubble; its PC is left as-is since
  // decode ignores the PC of an invalid slot.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush) begin
      instr_d = N'(NOP_INSTR);
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = d_instr;
      pc_d    = d_pc;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign ifid_instr = instr_q;
  assign ifid_pc    = pc_q;
  assign ifid_valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives imem_addr, fills IF/ID; HALT freezes fetch.
// Latency: word at address A appears on ifid_* one edge after pc==A with stall low.
// Backpressure: stall holds PC and IF/ID; redirect overrides stall and flushes IF/ID.
// Ports: clk, rst (async active-high), stall, redirect/redirect_pc from execute,
//        imem_addr/imem_instr to/from instruction memory, ifid_* to decode, halted status.
// Optional: define FETCH_PERF_CNT_EN to add perf_fetched / perf_stall 32-bit counters.
module fetch_stage
  import asip_pkg::*;
#(
  parameter int                N          = 24,
  parameter int                IMEM_DEPTH = asip_pkg::IMEM_DEPTH,
  parameter int                RESET_PC   = 0,
  parameter int                OPC_W      = asip_pkg::OPC_W,
  parameter logic [OPC_W-1:0]  HALT_OPC   = asip_pkg::HALT_OPC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         redirect,
  input  logic [N-1:0] redirect_pc,
  output logic [N-1:0] imem_addr,
  input  logic [N-1:0] imem_instr,
  output logic [N-1:0] ifid_instr,
  output logic [N-1:0] ifid_pc,
  output logic         ifid_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_stall,
`endif
  output logic         halted
);

  // IMEM_DEPTH is a power of two, so modulo is a mask of the low address bits.
  localparam logic [N-1:0] PC_MASK = N'(IMEM_DEPTH - 1);

  fetch_state_t state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic         halted_q, halted_d;
  logic         load, flush;
  logic         is_halt;

  assign is_halt = (imem_instr[N-1 -: OPC_W] == HALT_OPC);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    load     = 1'b0;
    flush    = 1'b0;
    if (redirect) begin
      // Redirect beats stall and is the only non-reset exit from HALTED.
      pc_d     = redirect_pc & PC_MASK;
      flush    = 1'b1;
      state_d  = RUN;
      halted_d = 1'b0;
    end else begin
      unique case (state_q)
        BOOT: state_d = RUN;  // one settle cycle for the memory after reset
        RUN: begin
          if (!stall) begin
            load = 1'b1;
            if (is_halt) begin
              // HALT itself issues normally; fetch then freezes on its address.
              state_d  = HALTED;
              halted_d = 1'b1;
            end else begin
              pc_d = (pc_q + N'(1)) & PC_MASK;
            end
          end
        end
        HALTED: flush = !stall;  // feed bubbles to decode unless it is stalled
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= BOOT;
      pc_q     <= N'(RESET_PC);
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  assign imem_addr = pc_q;
  assign halted    = halted_q;

  ifid_reg #(.N(N)) u_ifid_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .flush      (flush),
    .d_instr    (imem_instr),
    .d_pc       (pc_q),
    .ifid_instr (ifid_instr),
    .ifid_pc    (ifid_pc),
    .ifid_valid (ifid_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(load);
    perf_stall_d   = perf_stall_q + 32'((state_q == RUN) && stall && !redirect);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule
